// File: rtl/axi_fifo_packed.sv
// AXI-Stream FIFO for pre-packed words: pass-through when SIZE=0, otherwise a
// first-word-fall-through circular buffer of 2**SIZE entries with fill counts.
module axi_fifo_packed #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [15:0]      space,
  output logic [15:0]      occupied
);

  localparam int unsigned CNT_W = 16;

  if (SIZE == 0) begin : g_pass
    assign o_tdata  = i_tdata;
    assign o_tvalid = i_tvalid;
    assign i_tready = o_tready;
    assign space    = '0;
    assign occupied = '0;
  end else begin : g_fifo
    localparam int unsigned DEPTH = 2 ** SIZE;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SIZE-1:0]  wr_ptr;
    logic [SIZE-1:0]  rd_ptr;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_n;
    logic [CNT_W-1:0] space_q;
    logic             full_q;
    logic             valid_q;
    logic             push;
    logic             pop;

    // Ready comes only from the registered full flag; held low during reset.
    assign i_tready = ~full_q & ~reset;
    assign o_tvalid = valid_q;
    assign o_tdata  = valid_q ? mem[rd_ptr] : '0;
    assign space    = space_q;
    assign occupied = occ_q;

    assign push = i_tvalid & i_tready;
    assign pop  = o_tready & valid_q;

    // Next occupancy; simultaneous push and pop cancel out.
    always_comb begin
      occ_n = occ_q;
      if (push && !pop) begin
        occ_n = occ_q + CNT_W'(1);
      end else if (pop && !push) begin
        occ_n = occ_q - CNT_W'(1);
      end
    end

    // Pointers, counts and flags; clear wins over any transfer in its cycle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        occ_q   <= '0;
        space_q <= CNT_W'(DEPTH);
        full_q  <= 1'b0;
        valid_q <= 1'b0;
      end else if (clear) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        occ_q   <= '0;
        space_q <= CNT_W'(DEPTH);
        full_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + SIZE'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + SIZE'(1);
        end
        occ_q   <= occ_n;
        space_q <= CNT_W'(DEPTH) - occ_n;
        full_q  <= (occ_n == CNT_W'(DEPTH));
        valid_q <= (occ_n != '0);
      end
    end

    // Storage array is not reset; stale entries are never presented.
    always_ff @(posedge clk) begin
      if (push && !clear) begin
        mem[wr_ptr] <= i_tdata;
      end
    end
  end

endmodule

// File: tb/tb_axi_fifo_packed.sv
// Directed bench for axi_fifo_packed covering SIZE=0,1,2,3 instances.
module tb_axi_fifo_packed;

  logic clk;
  logic reset;
  int   passed;
  int   failed;
  int   total;

  // Instance A: SIZE=2, WIDTH=8
  logic        a_clear, a_ivalid, a_itready, a_ovalid, a_oready;
  logic [7:0]  a_idata, a_odata;
  logic [15:0] a_space, a_occ;
  // Instance B: SIZE=1, WIDTH=8
  logic        b_clear, b_ivalid, b_itready, b_ovalid, b_oready;
  logic [7:0]  b_idata, b_odata;
  logic [15:0] b_space, b_occ;
  // Instance C: SIZE=3, WIDTH=8
  logic        c_clear, c_ivalid, c_itready, c_ovalid, c_oready;
  logic [7:0]  c_idata, c_odata;
  logic [15:0] c_space, c_occ;
  // Instance D: SIZE=0, WIDTH=16
  logic        d_clear, d_ivalid, d_itready, d_ovalid, d_oready;
  logic [15:0] d_idata, d_odata;
  logic [15:0] d_space, d_occ;

  axi_fifo_packed #(.WIDTH(8), .SIZE(2)) u_a (
    .clk(clk), .reset(reset), .clear(a_clear),
    .i_tdata(a_idata), .i_tvalid(a_ivalid), .i_tready(a_itready),
    .o_tdata(a_odata), .o_tvalid(a_ovalid), .o_tready(a_oready),
    .space(a_space), .occupied(a_occ));

  axi_fifo_packed #(.WIDTH(8), .SIZE(1)) u_b (
    .clk(clk), .reset(reset), .clear(b_clear),
    .i_tdata(b_idata), .i_tvalid(b_ivalid), .i_tready(b_itready),
    .o_tdata(b_odata), .o_tvalid(b_ovalid), .o_tready(b_oready),
    .space(b_space), .occupied(b_occ));

  axi_fifo_packed #(.WIDTH(8), .SIZE(3)) u_c (
    .clk(clk), .reset(reset), .clear(c_clear),
    .i_tdata(c_idata), .i_tvalid(c_ivalid), .i_tready(c_itready),
    .o_tdata(c_odata), .o_tvalid(c_ovalid), .o_tready(c_oready),
    .space(c_space), .occupied(c_occ));

  axi_fifo_packed #(.WIDTH(16), .SIZE(0)) u_d (
    .clk(clk), .reset(reset), .clear(d_clear),
    .i_tdata(d_idata), .i_tvalid(d_ivalid), .i_tready(d_itready),
    .o_tdata(d_odata), .o_tvalid(d_ovalid), .o_tready(d_oready),
    .space(d_space), .occupied(d_occ));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int in_cnt;
    int out_cnt;
    logic [15:0] rnd_data;
    logic rnd_v;
    logic rnd_r;

    passed = 0; failed = 0; total = 0;
    reset = 1'b1;
    a_clear = 0; a_ivalid = 0; a_oready = 0; a_idata = '0;
    b_clear = 0; b_ivalid = 0; b_oready = 0; b_idata = '0;
    c_clear = 0; c_ivalid = 0; c_oready = 0; c_idata = '0;
    d_clear = 0; d_ivalid = 0; d_oready = 0; d_idata = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_ovalid", 32'(a_ovalid), 32'd0);
    check("rst_odata", 32'(a_odata), 32'd0);
    check("rst_occ", 32'(a_occ), 32'd0);
    check("rst_space", 32'(a_space), 32'd4);
    check("rst_itready", 32'(a_itready), 32'd1);

    // Async reset mid-cycle with a word stored
    a_ivalid = 1; a_idata = 8'hAA;
    tick();
    a_ivalid = 0;
    check("pre_async_occ", 32'(a_occ), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_ovalid", 32'(a_ovalid), 32'd0);
    check("async_occ", 32'(a_occ), 32'd0);
    check("async_space", 32'(a_space), 32'd4);
    check("async_itready_held", 32'(a_itready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_itready", 32'(a_itready), 32'd1);
    tick();

    // Fill SIZE=2 with o_tready low
    for (int i = 0; i < 4; i++) begin
      a_idata = 8'((i + 1) * 8'h11);
      a_ivalid = 1;
      tick();
      check("fill_occ", 32'(a_occ), 32'(i + 1));
    end
    check("full_itready", 32'(a_itready), 32'd0);
    check("full_space", 32'(a_space), 32'd0);
    a_idata = 8'h55;
    tick();
    check("fifth_rejected_occ", 32'(a_occ), 32'd4);
    a_ivalid = 0;
    a_oready = 1;
    for (int i = 0; i < 4; i++) begin
      check("drain_ovalid", 32'(a_ovalid), 32'd1);
      check("drain_data", 32'(a_odata), 32'((i + 1) * 8'h11));
      tick();
    end
    a_oready = 0;
    check("drained_occ", 32'(a_occ), 32'd0);
    check("drained_space", 32'(a_space), 32'd4);
    check("drained_ovalid", 32'(a_ovalid), 32'd0);

    // Streaming SIZE=1: 100 words, one per cycle
    in_cnt = 0;
    out_cnt = 0;
    b_oready = 1;
    for (int cyc = 0; cyc <= 100; cyc++) begin
      b_ivalid = (in_cnt < 100);
      b_idata = 8'(in_cnt);
      #0;
      if (cyc == 0) check("stream_first_empty", 32'(b_ovalid), 32'd0);
      check("stream_itready", 32'(b_itready), 32'd1);
      if (b_ovalid) begin
        check("stream_data", 32'(b_odata), 32'(8'(out_cnt)));
        out_cnt++;
      end
      if (b_ivalid && b_itready) in_cnt++;
      tick();
    end
    b_ivalid = 0;
    check("stream_out_count", 32'(out_cnt), 32'd100);
    check("stream_end_occ", 32'(b_occ), 32'd0);

    // Full SIZE=1 with simultaneous pop: push blocked that cycle
    b_oready = 0;
    b_ivalid = 1; b_idata = 8'hA1;
    tick();
    b_idata = 8'hA2;
    tick();
    check("b_full_occ", 32'(b_occ), 32'd2);
    check("b_full_itready", 32'(b_itready), 32'd0);
    b_idata = 8'hA3;
    b_oready = 1;
    #0;
    check("b_head", 32'(b_odata), 32'hA1);
    tick();
    check("b_pop_only_occ", 32'(b_occ), 32'd1);
    check("b_pop_only_head", 32'(b_odata), 32'hA2);
    check("b_reopen_itready", 32'(b_itready), 32'd1);
    tick();
    check("b_pushpop_occ", 32'(b_occ), 32'd1);
    check("b_pushpop_head", 32'(b_odata), 32'hA3);
    b_ivalid = 0;
    tick();
    b_oready = 0;
    check("b_empty_ovalid", 32'(b_ovalid), 32'd0);

    // Clear SIZE=3 holding 5 words, push during clear discarded
    c_ivalid = 1;
    for (int i = 1; i <= 5; i++) begin
      c_idata = 8'(i);
      tick();
    end
    check("c_occ5", 32'(c_occ), 32'd5);
    check("c_space3", 32'(c_space), 32'd3);
    c_clear = 1; c_idata = 8'h99; c_oready = 1;
    tick();
    c_clear = 0; c_ivalid = 0; c_oready = 0;
    check("clr_occ", 32'(c_occ), 32'd0);
    check("clr_space", 32'(c_space), 32'd8);
    check("clr_ovalid", 32'(c_ovalid), 32'd0);
    check("clr_itready", 32'(c_itready), 32'd1);
    c_ivalid = 1; c_idata = 8'h77;
    tick();
    c_ivalid = 0;
    check("clr_next_occ", 32'(c_occ), 32'd1);
    check("clr_next_head", 32'(c_odata), 32'h77);

    // Pass-through SIZE=0
    for (int i = 0; i < 8; i++) begin
      rnd_data = 16'($urandom);
      rnd_v = 1'($urandom);
      rnd_r = 1'($urandom);
      d_idata = rnd_data; d_ivalid = rnd_v; d_oready = rnd_r;
      #1;
      check("pt_data", 32'(d_odata), 32'(rnd_data));
      check("pt_ovalid", 32'(d_ovalid), 32'(rnd_v));
      check("pt_itready", 32'(d_itready), 32'(rnd_r));
      check("pt_counts", {d_space, d_occ}, 32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_fifo_packed.md
# axi_fifo_packed

Synchronous single-clock AXI-Stream FIFO that stores flat, pre-packed words of `WIDTH` bits. It sits under the SystemVerilog AXI4-Stream wrappers. Those wrappers pack tdata/tkeep/tuser/tlast from an AxiStreamPacketIf into one vector, pass it through this block, and unpack it on the far side. The block is used both as a deep buffer and, with small `SIZE`, as a pipeline stage. It reports fill level as `space` and `occupied` counts.

## Interface
- `WIDTH`, default 32: bit width of the packed word.
- `SIZE`, default 1: log2 of capacity. Legal range 0..15.
  - `SIZE=0`: combinational pass-through.
  - `SIZE>=1`: `2**SIZE` entries.

Ports:
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush, active-high.
- `i_tdata`  in  WIDTH  input word.
- `i_tvalid`  in  1  input valid.
- `i_tready`  out  1  input ready.
- `o_tdata`  out  WIDTH  output word.
- `o_tvalid`  out  1  output valid.
- `o_tready`  in  1  output ready.
- `space`  out  16  free entries.
- `occupied`  out  16  stored entries.

## Operation
- Transfer rules:
  - Input beat accepted when `i_tvalid && i_tready`.
  - Output beat consumed when `o_tvalid && o_tready`.
  - Strict first-in first-out order; no word is dropped, duplicated or reordered.
- `SIZE=0`:
  - `o_tdata=i_tdata`, `o_tvalid=i_tvalid`, `i_tready=o_tready`.
  - `space=0`, `occupied=0`.
  - `clear` and `reset` have no effect on the datapath.
- `SIZE>=1`:
  - Circular buffer of `2**SIZE` entries, plus read/write pointers and a registered count.
  - Output is first-word fall-through: the head entry is presented on `o_tdata` whenever `o_tvalid=1`.
- `i_tready`:
  - Equals `occupied != 2**SIZE`, from registered state only.
  - Has no combinational dependence on `o_tready`: a pop in the same cycle does not open a slot while full.
- `o_tvalid`:
  - Equals `occupied != 0`, registered.
  - `o_tdata` is don't-care when `o_tvalid=0`.
- Counters:
  - `space + occupied == 2**SIZE` at all times.
  - Per cycle: push-only gives `occupied+1`; pop-only gives `occupied-1`; push and pop together leave `occupied` unchanged.
- Pointers wrap modulo `2**SIZE`.
- `reset` (async) or `clear` (sync) empties the FIFO:
  - Pointers and count go to 0.
  - Stored words are discarded.
  - A push or pop in the same cycle as `clear` is ignored.
- `clear` has priority over push/pop.
- `reset` has priority over everything, including mid-transfer. The upstream must re-present any beat that was not accepted.

## Timing
- Reset values (`SIZE>=1`):
  - `o_tvalid=0`, `o_tdata=0`.
  - `i_tready=1` once `reset` deasserts. It is held 0 while `reset` is high.
  - `occupied=0`, `space=2**SIZE`.
- Latency: a word accepted at edge N has `o_tvalid=1` with that word after edge N, i.e. visible in cycle N+1.
- Counter update: `space`/`occupied` change on the edge following the transfer.
- Full behaviour: `i_tready=0` in the cycle after the `2**SIZE`-th unpopped push. It returns to 1 the cycle after the first pop.
- Empty behaviour: `o_tvalid=0` the cycle after the last word pops, unless a push landed on that same edge.
- Throughput: one beat per cycle in each direction simultaneously in steady state, for every `SIZE>=1`.
- No combinational paths from inputs to outputs when `SIZE>=1`.

## Test plan
- **Reset:** `SIZE=2`, `WIDTH=8`, assert `reset` asynchronously mid-cycle -> immediately `o_tvalid=0`, `occupied=0`, `space=4`. After release, `i_tready=1`.
- **Fill/drain:** `SIZE=2`, push 0x11,0x22,0x33,0x44 with `o_tready=0`.
  - -> `occupied` steps 1,2,3,4.
  - -> `i_tready=0` after the 4th push; a 5th push of 0x55 is not accepted.
  - Then `o_tready=1` -> outputs 0x11,0x22,0x33,0x44 in order, `occupied` back to 0, `space=4`.
- **Streaming:** `SIZE=1`, `i_tvalid=o_tready=1` continuously with an incrementing 0..99 -> 100 words out in order, one per cycle, first output 1 cycle after first accept.
- **Full + simultaneous pop:** `SIZE=1` full (2 entries), `o_tready=1` and `i_tvalid=1` -> pop occurs, push not accepted that cycle, `occupied=1`. Next cycle push accepted and `occupied` stays 1.
- **Clear:** `SIZE=3` holding 5 words, pulse `clear` with `i_tvalid=1` -> next cycle `occupied=0`, `space=8`, `o_tvalid=0`, and the clear-cycle word is discarded.
- **Pass-through:** `SIZE=0`, toggle `i_tvalid`/`o_tready` randomly -> outputs mirror the inputs combinationally, `space=occupied=0`.
